// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an incoming PWM waveform
// in clock cycles.
//
// Each rising edge after the first one closes a period and produces one
// measurement, so a steady waveform gives a pulse per period. If no edge
// arrives for TIMEOUT cycles, the outputs are zeroed and a sticky timeout
// flag is raised.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_pwm      PWM input, asynchronous to clk
//   cap_en     capture enable; low aborts and parks the block in IDLE
//   period     last measured period in cycles (H + L), registered
//   high_time  last measured high time in cycles (H), registered
//   cap_valid  one-cycle pulse when period/high_time take a new measurement
//   timeout    sticky stuck-input flag; cleared by a measurement or by cap_en=0
//
// Handshake: cap_valid is a pure strobe with no ready. period and high_time
// are valid on the cycle cap_valid is high and hold until the next update.
module pwm_capture #(
  parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_pwm,
  input  logic        cap_en,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        cap_valid,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  // FSM state kept as a named signal so checkers can bind to it directly
  state_t state;
  state_t state_nxt;

  logic s1, s2, s3;
  logic rise, fall;
  logic [31:0] cnt;
  logic [31:0] hi_cnt;
  logic at_limit;

  // Control strobes decoded from state and input events
  logic cnt_load;
  logic cnt_inc;
  logic hi_load;
  logic meas;
  logic tmo;
  logic abort;

  logic [32:0] sum;
  logic [31:0] sum_sat;

  // Two flops for metastability; the third gives a delayed copy for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_pwm;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign at_limit = (cnt == TIMEOUT);

  // hi_cnt and cnt are both bounded by TIMEOUT, so a 33-bit sum cannot
  // overflow; saturate it back into the 32-bit output.
  assign sum     = {1'b0, cnt} + {1'b0, hi_cnt};
  assign sum_sat = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (!cap_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = ARM;
        ARM:  if (rise) state_nxt = HIGH;
        HIGH: begin
          if (fall) begin
            state_nxt = LOW;
          end else if (at_limit) begin
            state_nxt = ARM;
          end
        end
        LOW: begin
          if (rise) begin
            state_nxt = HIGH;
          end else if (at_limit) begin
            state_nxt = ARM;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output/strobe decode. An edge arriving in the same cycle the counter
  // hits TIMEOUT wins over the timeout.
  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    hi_load  = 1'b0;
    meas     = 1'b0;
    tmo      = 1'b0;
    abort    = 1'b0;
    if (!cap_en) begin
      abort = 1'b1;
    end else begin
      case (state)
        ARM: begin
          if (rise) cnt_load = 1'b1;
        end
        HIGH: begin
          if (fall) begin
            hi_load  = 1'b1;
            cnt_load = 1'b1;
          end else if (at_limit) begin
            tmo = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            meas     = 1'b1;
            cnt_load = 1'b1;
          end else if (at_limit) begin
            tmo = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counter: 1 on a period/segment start, +1 while measuring, otherwise 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (cnt_load) begin
      cnt <= 32'd1;
    end else if (cnt_inc) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt <= 32'd0;
    end else if (hi_load) begin
      hi_cnt <= cnt;
    end
  end

  // Result registers. meas and tmo are mutually exclusive, and abort
  // excludes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= 32'd0;
      high_time <= 32'd0;
      cap_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cap_valid <= meas;
      if (meas) begin
        period    <= sum_sat;
        high_time <= hi_cnt;
        timeout   <= 1'b0;
      end else if (tmo) begin
        period    <= 32'd0;
        high_time <= 32'd0;
        timeout   <= 1'b1;
      end else if (abort) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture. The waveform is described as high/low segment
// lengths in clock cycles. The reference model works at the level of whole
// periods: once armed by a rising edge, every later rising edge must produce
// one measurement of (H + L, H) for the period that just closed.
module tb_pwm_capture;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_pwm = 1'b0;
  logic        cap_en = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        cap_valid;
  logic        timeout;

  pwm_capture #(.TIMEOUT(32'd100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_pwm     (i_pwm),
    .cap_en    (cap_en),
    .period    (period),
    .high_time (high_time),
    .cap_valid (cap_valid),
    .timeout   (timeout)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];     // {period, high_time}
  logic [63:0] mon_e;
  int cyc = 0;
  int n_pulses = 0;
  int pulse_cyc = -1;
  int tmo_cyc = -1;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic prev_tmo = 1'b0;

  // reference model state
  bit   m_armed = 1'b0;
  bit   model_on = 1'b1;
  int   m_h = 0;
  int   m_l = 0;
  int   n_exp = 0;
  logic last_in = 1'b0;

  typedef struct {
    int          h;
    int          l;
    int          n;
    logic [31:0] exp_p;
    logic [31:0] exp_h;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle of input. The model sees the same segment lengths the
  // DUT sees, since the synchroniser delays rises and falls equally.
  task automatic drive_cycle(input logic v, input logic en);
    logic [31:0] p;
    logic [31:0] h;
    @(negedge clk);
    cap_en = en;
    if (!en) m_armed = 1'b0;
    if (v && !last_in) begin
      rise_cyc = cyc;
      if (m_armed && model_on) begin
        p = 32'(m_h + m_l);
        h = 32'(m_h);
        exp_q.push_back({p, h});
        n_exp++;
      end
      if (en) begin
        m_armed = 1'b1;
        m_h = 0;
        m_l = 0;
      end
    end
    i_pwm = v;
    last_in = v;
    if (m_armed) begin
      if (v) m_h++;
      else m_l++;
      // a segment longer than TIMEOUT cycles trips the stuck detector
      if (m_h > TMO || m_l > TMO) m_armed = 1'b0;
    end
  endtask

  task automatic hold(input logic v, input int n, input logic en);
    for (int i = 0; i < n; i++) drive_cycle(v, en);
  endtask

  task automatic periods(input int h, input int l, input int n, input logic en);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, h, en);
      hold(1'b0, l, en);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n) begin
        if (cap_valid) begin
          n_pulses++;
          pulse_cyc = cyc;
          chk("valid_width", {31'd0, prev_valid}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_valid: got pulse at cycle %0d with %0d/%0d, expected none",
                     cyc, period, high_time);
          end else begin
            mon_e = exp_q.pop_front();
            chk("period", period, mon_e[63:32]);
            chk("high_time", high_time, mon_e[31:0]);
          end
        end
        if (timeout && !prev_tmo) tmo_cyc = cyc;
      end
      prev_valid = cap_valid;
      prev_tmo = timeout;
    end
  end

  // ---------------- test ----------------
  initial begin : main
    int base;
    int base_e;
    int r;

    vecs[0] = '{3, 7, 4, 32'd10, 32'd3};
    vecs[1] = '{1, 1, 6, 32'd2, 32'd1};
    vecs[2] = '{5, 5, 3, 32'd10, 32'd5};
    vecs[3] = '{2, 2, 4, 32'd4, 32'd2};
    vecs[4] = '{7, 1, 3, 32'd8, 32'd7};
    vecs[5] = '{1, 12, 3, 32'd13, 32'd1};

    // reset with input toggling
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) drive_cycle(1'(i % 2), 1'b0);
    chk("rst_period", period, 32'd0);
    chk("rst_high_time", high_time, 32'd0);
    chk("rst_cap_valid", {31'd0, cap_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    periods(2, 2, 6, 1'b0);
    chk("disabled_no_valid", 32'(n_pulses), 32'd0);

    // loopback arr=9 ccr=3, then drop cap_en mid-HIGH
    model_on = 1'b1;
    hold(1'b0, 4, 1'b1);
    base = n_pulses;
    periods(3, 7, 4, 1'b1);
    drive_cycle(1'b1, 1'b1);
    r = rise_cyc;
    hold(1'b1, 3, 1'b1);
    chk("latency", 32'(pulse_cyc - r), 32'd3);
    chk("loopback_count", 32'(n_pulses - base), 32'd4);
    drive_cycle(1'b1, 1'b0);
    hold(1'b1, 2, 1'b0);
    periods(3, 7, 2, 1'b0);
    chk("drop_period_hold", period, 32'd10);
    chk("drop_high_hold", high_time, 32'd3);
    chk("drop_timeout", {31'd0, timeout}, 32'd0);
    chk("drop_no_valid", 32'(n_pulses - base), 32'd4);
    hold(1'b0, 4, 1'b1);
    periods(3, 7, 1, 1'b1);
    chk("reenable_arm_only", 32'(n_pulses - base), 32'd4);
    drive_cycle(1'b1, 1'b1);
    r = rise_cyc;
    hold(1'b1, 3, 1'b1);
    chk("reenable_latency", 32'(pulse_cyc - r), 32'd3);
    chk("reenable_count", 32'(n_pulses - base), 32'd5);
    hold(1'b0, 4, 1'b0);

    // stuck input held high after one valid period
    hold(1'b0, 4, 1'b1);
    base = n_pulses;
    periods(3, 7, 1, 1'b1);
    drive_cycle(1'b1, 1'b1);
    r = rise_cyc;
    hold(1'b1, TMO + 10, 1'b1);
    chk("timeout_latency", 32'(tmo_cyc - r), 32'(TMO + 3));
    chk("timeout_flag", {31'd0, timeout}, 32'd1);
    chk("timeout_period", period, 32'd0);
    chk("timeout_high", high_time, 32'd0);
    chk("timeout_count", 32'(n_pulses - base), 32'd1);
    hold(1'b0, 2, 1'b1);
    periods(2, 2, 1, 1'b1);
    chk("timeout_sticky", {31'd0, timeout}, 32'd1);
    drive_cycle(1'b1, 1'b1);
    hold(1'b1, 1, 1'b1);
    hold(1'b0, 2, 1'b1);
    chk("resume_timeout_clr", {31'd0, timeout}, 32'd0);
    chk("resume_period", period, 32'd4);
    chk("resume_high", high_time, 32'd2);
    hold(1'b0, 4, 1'b0);

    // duty change at a rising edge
    hold(1'b0, 4, 1'b1);
    base = n_pulses;
    periods(3, 7, 3, 1'b1);
    periods(5, 5, 3, 1'b1);
    drive_cycle(1'b1, 1'b1);
    hold(1'b1, 3, 1'b1);
    chk("duty_count", 32'(n_pulses - base), 32'd6);
    chk("duty_queue", 32'(exp_q.size()), 32'd0);
    chk("duty_last_high", high_time, 32'd5);
    hold(1'b0, 4, 1'b0);

    // table-driven steady waveforms
    model_on = 1'b0;
    for (int v = 0; v < 6; v++) begin
      hold(1'b0, 4, 1'b1);
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back({vecs[v].exp_p, vecs[v].exp_h});
      base = n_pulses;
      periods(vecs[v].h, vecs[v].l, vecs[v].n, 1'b1);
      drive_cycle(1'b1, 1'b1);
      hold(1'b0, 4, 1'b1);
      chk("vec_count", 32'(n_pulses - base), 32'(vecs[v].n));
      chk("vec_queue", 32'(exp_q.size()), 32'd0);
      chk("vec_period", period, vecs[v].exp_p);
      chk("vec_high", high_time, vecs[v].exp_h);
      hold(1'b0, 3, 1'b0);
    end
    model_on = 1'b1;

    // randomized waveforms against the model
    for (int b = 0; b < 3; b++) begin
      hold(1'b0, 4, 1'b1);
      base = n_pulses;
      base_e = n_exp;
      for (int k = 0; k < 25; k++) begin
        periods(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1, 1'b1);
      end
      drive_cycle(1'b1, 1'b1);
      hold(1'b0, 4, 1'b1);
      chk("rand_count", 32'(n_pulses - base), 32'(n_exp - base_e));
      chk("rand_queue", 32'(exp_q.size()), 32'd0);
      hold(1'b0, 3, 1'b0);
    end

    // asynchronous reset mid-HIGH
    hold(1'b0, 4, 1'b1);
    periods(3, 7, 2, 1'b1);
    drive_cycle(1'b1, 1'b1);
    hold(1'b1, 3, 1'b1);
    chk("pre_reset_period", period, 32'd10);
    chk("pre_reset_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_period", period, 32'd0);
    chk("async_rst_high", high_time, 32'd0);
    chk("async_rst_valid", {31'd0, cap_valid}, 32'd0);
    chk("async_rst_timeout", {31'd0, timeout}, 32'd0);
    hold(1'b0, 3, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles. It is the receive-side counterpart of the team's PWM generator. For a generator programmed with reload value `arr` and compare value `ccr` (where `ccr <= arr`), this block reports `period = arr + 1` and `high_time = ccr`. It is used to check buzzer and tone outputs in loopback and to decode external PWM control inputs.

## Interface
Parameters:
- `TIMEOUT`, default `32'd50_000_000`: the number of cycles with no edge after which the input counts as stuck. Legal range is 2 to 2^32-1.

Ports:
- `clk`  input  1: system clock; every register uses its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `i_pwm`  input  1: PWM input; asynchronous to `clk`.
- `cap_en`  input  1: enables capture.
- `period`  output  32: cycles from one rising edge to the next; registered.
- `high_time`  output  32: cycles the input was high within that period; registered.
- `cap_valid`  output  1: one-cycle pulse when `period` and `high_time` update with a measurement.
- `timeout`  output  1: set when no edge arrives within `TIMEOUT` cycles; sticky.

## Operation
- Input conditioning:
  - Chain `s1 <= i_pwm; s2 <= s1; s3 <= s2`.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
  - At most one edge event per cycle, so there is no simultaneous rise/fall case.
- Cycle counter `cnt`, 32 bits:
  - Loads 1 on every detected `rise` and on `fall` from HIGH.
  - Otherwise increments in HIGH and LOW.
  - Held at 0 in IDLE and ARM.
  - `TIMEOUT` bounds `cnt`, so it never wraps.
- State machine: IDLE, ARM, HIGH, LOW.
  - IDLE: entered on reset, and on the next edge whenever `cap_en` = 0 from any state. Goes to ARM when `cap_en` = 1.
  - ARM: discards the partial period in progress. On `rise`: `cnt <= 1`, go to HIGH.
  - HIGH: on `fall`: `hi_cnt <= cnt` (equal to H, the high cycles), go to LOW.
  - LOW: on `rise`:
    - `period <= cnt + hi_cnt`, which is H + L.
    - `high_time <= hi_cnt`.
    - `cap_valid <= 1`, `timeout <= 0`.
    - `cnt <= 1`, go to HIGH.
    - Measurement is back-to-back: every rising edge after the first closes one period.
- Timeout (HIGH or LOW only): when `cnt == TIMEOUT` and no edge arrives that cycle:
  - `period <= 0`, `high_time <= 0`, `timeout <= 1`.
  - No `cap_valid`.
  - Go to ARM.
  - On a constant input, `timeout` is not re-pulsed; it stays set.
- Dropping `cap_en`:
  - Aborts any measurement in progress with no `cap_valid`.
  - `period` and `high_time` hold their last values.
  - `timeout` clears.
  - Re-enabling requires a fresh ARM rise plus one full period before the next `cap_valid`.
- Width rules:
  - `hi_cnt` and the `cnt` value held in LOW are each at most `TIMEOUT`.
  - Their sum is computed in 33 bits and saturates to 2^32-1.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `cap_valid` = 0, `timeout` = 0, state IDLE, `s1`/`s2`/`s3` = 0, `cnt` = 0, `hi_cnt` = 0.
- Latency:
  - If clock edge k first samples the closing rising edge (`s1` = 1), `cap_valid` is high during the cycle after edge k+2.
  - `period` and `high_time` change on that same edge and are stable until the next update.
- `cap_valid` is exactly one cycle wide. The minimum spacing between pulses is 2 cycles.
- Minimum measurable waveform: H ≥ 1 and L ≥ 1 cycles after synchronisation, giving period ≥ 2.
- Pulses narrower than one clock may be missed. This is permitted and not flagged.
- Asynchronous reset mid-measurement returns every register to its reset value immediately.

## Test plan
- Reset: assert `rst_n` = 0 with `i_pwm` toggling. All outputs read 0. After release with `cap_en` = 0, `cap_valid` never pulses.
- Loopback from the generator with arr = 9, ccr = 3, `cap_en` = 1:
  - First `cap_valid` follows the second rising edge, reading `period` = 10, `high_time` = 3.
  - It then pulses every 10 cycles with the same values.
- Minimum waveform H = 1, L = 1: `cap_valid` every 2 cycles, `period` = 2, `high_time` = 1.
- Duty change at a rising edge from H=3/L=7 to H=5/L=5: the next `cap_valid` reads 10/5, and there is no spurious extra pulse.
- Stuck input with `TIMEOUT` = 100, held high after one valid period:
  - Exactly 100 cycles after the last rise, `timeout` = 1, `period` = 0, `high_time` = 0, and there is no `cap_valid`.
  - After toggling resumes at H=2/L=2, the first `cap_valid` reads 4/2 and clears `timeout`.
- Drop `cap_en` mid-HIGH after a valid 10/3 measurement:
  - No `cap_valid` occurs; outputs hold 10/3.
  - On re-enable, the first `cap_valid` arrives only after an ARM rise plus one full period.
